// File: rtl/wb_pkg.sv
// Shared writeback types: destination/data entry plus default buffer depth and producer count.
// Entry widths follow the WIDTH / NR_REG build macros, 32 / 32 when not set.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef NR_REG
`define NR_REG 32
`endif

package wb_pkg;
  localparam int WB_WIDTH  = `WIDTH;
  localparam int WB_NR_REG = `NR_REG;
  localparam int AW        = $clog2(WB_NR_REG);
  localparam int WB_DEPTH  = 4;
  localparam int WB_NSRC   = 4;

  typedef struct packed {
    logic [AW-1:0]       rd;
    logic [WB_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order writeback buffer, 2 pushes / 2 pops per cycle, entries presented oldest-first.
// Pushed entries are visible the cycle after the edge; the caller never pushes past free space.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic [1:0]             i_push_vld,
  input  wb_entry_t              i_push0_ent,
  input  wb_entry_t              i_push1_ent,
  input  logic [1:0]             i_pop_n,
  output wb_entry_t              o_age_ent [DEPTH],
  output logic [DEPTH-1:0]       o_age_vld,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  wb_entry_t     r_mem [DEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_tail;
  logic [CW-1:0] w_push_n;
  logic [IW-1:0] w_wr0;
  logic [IW-1:0] w_wr1;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign o_count  = r_tail - r_head;
  assign w_push_n = CW'(i_push_vld[0]) + CW'(i_push_vld[1]);
  assign w_wr0    = r_tail[IW-1:0];
  assign w_wr1    = r_tail[IW-1:0] + IW'(1);

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [IW-1:0] w_idx;
    assign w_idx        = r_head[IW-1:0] + IW'(g);
    assign o_age_ent[g] = r_mem[w_idx];
    assign o_age_vld[g] = (CW'(g) < o_count);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_tail <= r_tail + w_push_n;
      r_head <= r_head + CW'(i_pop_n);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push_vld[0]) r_mem[w_wr0] <= i_push0_ent;
    if (i_push_vld[1]) r_mem[w_wr1] <= i_push1_ent;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: grants up to two producers/cycle into wb_fifo, drains up to two entries to the register file 1 cycle later.
// Ready tracks registered free space only (drain not credited), drops under flush/reset; forwarding built only with WB_BYPASS_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef NR_REG
`define NR_REG 32
`endif

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH  = `WIDTH,
  parameter int NR_REG = `NR_REG,
  parameter int NSRC   = WB_NSRC,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NSRC-1:0]                   src_valid,
  output logic [NSRC-1:0]                   src_ready,
  input  logic [NSRC*$clog2(NR_REG)-1:0]    src_rd,
  input  logic [NSRC*WIDTH-1:0]             src_data,
  input  logic                              wb_stall,
  input  logic                              flush,
  output logic [$clog2(NR_REG)-1:0]         rd1,
  output logic [$clog2(NR_REG)-1:0]         rd2,
  output logic [WIDTH-1:0]                  wdata1,
  output logic [WIDTH-1:0]                  wdata2,
  output logic                              wen1,
  output logic                              wen2,
  input  logic [4*$clog2(NR_REG)-1:0]       fw_rs,
  output logic [3:0]                        fw_hit,
  output logic [4*WIDTH-1:0]                fw_data,
  output logic [$clog2(DEPTH):0]            count
);
  localparam int RW = $clog2(NR_REG);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             w_live;
  wb_entry_t        w_age_ent [DEPTH];
  logic [DEPTH-1:0] w_age_vld;
  logic [CW-1:0]    w_free;
  logic [1:0]       w_lanes;
  logic [1:0]       w_push_vld;
  wb_entry_t        w_push0_ent;
  wb_entry_t        w_push1_ent;
  logic [1:0]       w_pop_n;
  logic             w_same_rd;

  assign w_live  = reset && !flush;
  assign w_free  = CW'(DEPTH) - count;
  assign w_lanes = (w_free >= CW'(2)) ? 2'd2 : w_free[1:0];

  // Grant is positional: source i may go if fewer than w_lanes older sources want a lane.
  always_comb begin
    int n_below;
    n_below   = 0;
    src_ready = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = w_live && (n_below < int'(w_lanes));
      if (src_valid[i]) n_below = n_below + 1;
    end
  end

  always_comb begin
    logic slot;
    slot        = 1'b0;
    w_push_vld  = '0;
    w_push0_ent = '0;
    w_push1_ent = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_valid[i] && src_ready[i] && (src_rd[i*RW +: RW] != '0)) begin
        if (!slot) begin
          w_push_vld[0]    = 1'b1;
          w_push0_ent.rd   = src_rd[i*RW +: RW];
          w_push0_ent.data = src_data[i*WIDTH +: WIDTH];
        end else begin
          w_push_vld[1]    = 1'b1;
          w_push1_ent.rd   = src_rd[i*RW +: RW];
          w_push1_ent.data = src_data[i*WIDTH +: WIDTH];
        end
        slot = 1'b1;
      end
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_clear     (flush),
    .i_push_vld  (w_push_vld),
    .i_push0_ent (w_push0_ent),
    .i_push1_ent (w_push1_ent),
    .i_pop_n     (w_pop_n),
    .o_age_ent   (w_age_ent),
    .o_age_vld   (w_age_vld),
    .o_count     (count)
  );

  assign w_pop_n = (!w_live || wb_stall) ? 2'd0 :
                   (count >= CW'(2))     ? 2'd2 :
                   (count == '0)         ? 2'd0 : 2'd1;

  // Both entries still drain on a same-rd pair; only the older write is squashed.
  assign w_same_rd = (w_age_ent[0].rd == w_age_ent[1].rd);
  assign wen2      = (w_pop_n == 2'd2);
  assign wen1      = (w_pop_n != 2'd0) && !(wen2 && w_same_rd);
  assign rd1       = w_age_ent[0].rd;
  assign wdata1    = w_age_ent[0].data;
  assign rd2       = w_age_ent[1].rd;
  assign wdata2    = w_age_ent[1].data;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match leaves the youngest data.
  always_comb begin
    fw_hit  = '0;
    fw_data = '0;
    for (int k = 0; k < 4; k++) begin
      for (int o = 0; o < DEPTH; o++) begin
        if ((fw_rs[k*RW +: RW] != '0) && w_age_vld[o] &&
            (w_age_ent[o].rd == fw_rs[k*RW +: RW])) begin
          fw_hit[k]                 = 1'b1;
          fw_data[k*WIDTH +: WIDTH] = w_age_ent[o].data;
        end
      end
    end
  end
`else
  logic unused_fw;
  assign fw_hit    = '0;
  assign fw_data   = '0;
  assign unused_fw = ^{fw_rs, w_age_vld};
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued as stimulus is driven
// and popped by a monitor whenever wen1/wen2 fire; point checks cover ready, count and flags.
module tb_wb_arbiter;
  localparam int W  = 32;
  localparam int RW = 5;
  localparam int NS = 4;
  localparam int D  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*RW-1:0]  src_rd;
  logic [NS*W-1:0]   src_data;
  logic              wb_stall;
  logic              flush;
  logic [RW-1:0]     rd1, rd2;
  logic [W-1:0]      wdata1, wdata2;
  logic              wen1, wen2;
  logic [4*RW-1:0]   fw_rs;
  logic [3:0]        fw_hit;
  logic [4*W-1:0]    fw_data;
  logic [2:0]        count;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [W-1:0]  d;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  wb_arbiter #(
    .WIDTH  (W),
    .NR_REG (32),
    .NSRC   (NS),
    .DEPTH  (D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .wb_stall  (wb_stall),
    .flush     (flush),
    .rd1       (rd1),
    .rd2       (rd2),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .wen1      (wen1),
    .wen2      (wen2),
    .fw_rs     (fw_rs),
    .fw_hit    (fw_hit),
    .fw_data   (fw_data),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i, input logic [RW-1:0] rd, input logic [W-1:0] d);
    src_valid[i]        = 1'b1;
    src_rd[i*RW +: RW]  = rd;
    src_data[i*W +: W]  = d;
  endtask

  task automatic expect_wr(input logic [RW-1:0] rd, input logic [W-1:0] d);
    exp_t e;
    e.rd = rd;
    e.d  = d;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic sb_check(input int port, input logic [RW-1:0] rd, input logic [W-1:0] d);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_extra_port%0d: observed rd=%0d data=0x%0h expected no write", port, rd, d);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert ({rd, d} === {e.rd, e.d}) else begin
        errors++;
        $error("FAIL sb_write_port%0d: observed rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
               port, rd, d, e.rd, e.d);
      end
    end
  endtask

  // Port 1 is older, so it is checked against the queue first.
  always @(negedge clock) begin
    if (wen1) sb_check(1, rd1, wdata1);
    if (wen2) sb_check(2, rd2, wdata2);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; src_valid = '0; src_rd = '0; src_data = '0;
    wb_stall = 1'b0; flush = 1'b0; fw_rs = '0;
    repeat (2) step();
    mid();
    chk("rst_count", 64'(count), 0);
    chk("rst_wen", {wen1, wen2}, 0);
    chk("rst_ready", 64'(src_ready), 0);
    chk("rst_fw_hit", 64'(fw_hit), 0);
    step();
    reset = 1'b1;
    mid();
    chk("idle_ready", 64'(src_ready), 4'b1111);

    // Basic accept
    step();
    drv(0, 5'd5, 32'hA5); expect_wr(5'd5, 32'hA5);
    mid();
    chk("basic_ready0", 64'(src_ready[0]), 1);
    step();
    src_valid = '0;
    mid();
    chk("basic_rd1", 64'(rd1), 5);
    chk("basic_wdata1", 64'(wdata1), 32'hA5);
    chk("basic_wen", {wen1, wen2}, 2'b10);
    chk("basic_count", 64'(count), 1);

    // Priority: four valid, two granted per cycle
    step();
    for (int i = 0; i < NS; i++) begin
      drv(i, 5'(i + 1), 32'h100 + 32'(i));
      expect_wr(5'(i + 1), 32'h100 + 32'(i));
    end
    mid();
    chk("prio_ready", 64'(src_ready), 4'b0011);
    step();
    src_valid[1:0] = 2'b00;
    mid();
    chk("prio_wen", {wen1, wen2}, 2'b11);
    chk("prio_rd1", 64'(rd1), 1);
    chk("prio_rd2", 64'(rd2), 2);
    chk("prio_ready23", 64'(src_ready[3:2]), 2'b11);
    step();
    src_valid = '0;
    mid();
    chk("prio_count2", 64'(count), 2);
    chk("prio_rd1b", 64'(rd1), 3);
    chk("prio_rd2b", 64'(rd2), 4);

    // Fill under stall, then full
    step();
    wb_stall = 1'b1;
    drv(0, 5'd10, 32'hA10); expect_wr(5'd10, 32'hA10);
    drv(1, 5'd11, 32'hA11); expect_wr(5'd11, 32'hA11);
    mid();
    chk("fill_count0", 64'(count), 0);
    chk("fill_ready0", 64'(src_ready), 4'b0011);
    step();
    drv(0, 5'd12, 32'hA12); expect_wr(5'd12, 32'hA12);
    drv(1, 5'd13, 32'hA13); expect_wr(5'd13, 32'hA13);
    mid();
    chk("fill_count2", 64'(count), 2);
    chk("stall_wen", {wen1, wen2}, 0);
    step();
    mid();
    chk("full_count", 64'(count), 4);
    chk("full_ready", 64'(src_ready), 0);
    step();
    wb_stall = 1'b0;
    mid();
    chk("full_drain_ready", 64'(src_ready), 0);
    chk("full_drain_wen", {wen1, wen2}, 2'b11);
    chk("full_drain_rd1", 64'(rd1), 10);
    step();
    src_valid = '0;
    mid();
    chk("drain_count2", 64'(count), 2);
    chk("drain_rd1", 64'(rd1), 12);

    // DEPTH-1 grant and flush beating drain
    step();
    wb_stall = 1'b1;
    drv(0, 5'd20, 32'h20); drv(1, 5'd21, 32'h21);
    step();
    src_valid = '0;
    drv(0, 5'd22, 32'h22);
    step();
    src_valid = '0;
    drv(1, 5'd26, 32'h26); drv(2, 5'd27, 32'h27);
    mid();
    chk("c3_count", 64'(count), 3);
    chk("c3_ready", 64'(src_ready & src_valid), 4'b0010);
    #1;
    flush = 1'b1; wb_stall = 1'b0;
    #1;
    chk("flush_ready", 64'(src_ready), 0);
    chk("flush_wen", {wen1, wen2}, 0);
    step();
    flush = 1'b0; src_valid = '0;
    mid();
    chk("flush_count", 64'(count), 0);
    chk("flush_wen_after", {wen1, wen2}, 0);

    // Reset mid-stream behaves like flush
    step();
    wb_stall = 1'b1;
    drv(0, 5'd23, 32'h23); drv(1, 5'd24, 32'h24);
    step();
    src_valid = '0;
    drv(0, 5'd25, 32'h25);
    step();
    src_valid = '0; reset = 1'b0; wb_stall = 1'b0;
    mid();
    chk("rreset_hold_count", 64'(count), 3);
    chk("rreset_wen", {wen1, wen2}, 0);
    chk("rreset_ready", 64'(src_ready), 0);
    step();
    reset = 1'b1;
    mid();
    chk("rreset_count", 64'(count), 0);
    chk("rreset_wen_after", {wen1, wen2}, 0);
    chk("rreset_ready_live", 64'(src_ready), 4'b1111);

    // Same-register conflict: younger wins
    step();
    drv(0, 5'd7, 32'h11); drv(1, 5'd7, 32'h22); expect_wr(5'd7, 32'h22);
    step();
    src_valid = '0;
    mid();
    chk("conf_wen", {wen1, wen2}, 2'b01);
    chk("conf_rd2", 64'(rd2), 7);
    chk("conf_wdata2", 64'(wdata2), 32'h22);

    // rd==0 consumes a lane but no slot
    step();
    drv(0, 5'd0, 32'hDEAD); drv(1, 5'd8, 32'h88); expect_wr(5'd8, 32'h88);
    step();
    src_valid = '0;
    mid();
    chk("drop_count", 64'(count), 1);
    chk("drop_wen", {wen1, wen2}, 2'b10);
    chk("drop_rd1", 64'(rd1), 8);

    // Forwarding from pending entries
    step();
    wb_stall = 1'b1;
    drv(0, 5'd9, 32'h1); drv(1, 5'd9, 32'h2); expect_wr(5'd9, 32'h2);
    step();
    src_valid = '0;
    fw_rs = {5'd9, 5'd3, 5'd0, 5'd9};
    mid();
`ifdef WB_BYPASS_EN
    chk("byp_hit", 64'(fw_hit), 4'b1001);
    chk("byp_data0", 64'(fw_data[31:0]), 32'h2);
    chk("byp_data3", 64'(fw_data[127:96]), 32'h2);
`else
    chk("byp_hit_off", 64'(fw_hit), 0);
    chk("byp_data_off", 64'(fw_data != '0), 0);
`endif
    step();
    wb_stall = 1'b0;
    mid();
    chk("byp_wen", {wen1, wen2}, 2'b01);
    step();
    mid();
    chk("byp_hit_empty", 64'(fw_hit), 0);
    chk("end_count", 64'(count), 0);
    repeat (2) step();
    chk("sb_empty", 64'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and buffer sitting directly upstream of the dual-write-port register file. Collects results from up to four producers (two ALUs, multiplier/divider, LSU) over valid/ready handshakes, queues them in a small in-order buffer, and drains up to two per cycle onto the register file's `rd1/wdata1/wen1` and `rd2/wdata2/wen2` ports. Optionally forwards pending, not-yet-written results to the four read ports.

## Interface
- `WIDTH`, default `` `WIDTH `` (32): data width.
- `NR_REG`, default `` `NR_REG `` (32): architectural registers; `AW = $clog2(NR_REG)`.
- `NSRC`, default 4: producer count; lower index has higher priority and is older within a cycle.
- `DEPTH`, default 4: buffer entries, power of two, ≥ 2.
- `clock` in 1: sole clock, all state on posedge.
- `reset` in 1: synchronous, active-low (`reset==0` resets on the clock edge).
- `src_valid` in NSRC: producer i has a result.
- `src_ready` out NSRC: producer i accepted this cycle if `src_valid[i]`.
- `src_rd` in NSRC*AW: destination register, packed, lane i at `[i*AW +: AW]`.
- `src_data` in NSRC*WIDTH: result, packed likewise.
- `wb_stall` in 1: hold drain; the buffer keeps filling.
- `flush` in 1: discard all pending entries.
- `rd1`, `rd2` out AW: register-file write addresses (port 1 older).
- `wdata1`, `wdata2` out WIDTH: write data.
- `wen1`, `wen2` out 1: write enables.
- `fw_rs` in 4*AW: read addresses mirrored from the register-file `rs1..rs4`.
- `fw_hit` out 4: pending entry matches `fw_rs[k]`.
- `fw_data` out 4*WIDTH: forwarded data.
- `count` out $clog2(DEPTH)+1: occupied entries, registered.

## Operation
- Buffer: circular FIFO, head/tail pointers with an extra wrap bit, `count` = tail − head.
- Enqueue lanes: `k = min(2, DEPTH − count)`, using registered `count` only; same-cycle drain is not credited.
- `src_ready[i] = 1` iff `flush==0` and fewer than `k` lower-index sources are valid. `src_ready[i]` never depends on `src_valid[i]`.
- Accepted sources enqueue in index order; the lower index lands closer to the head.
- An accepted entry with `rd==0` is dropped. It consumes an enqueue lane but no buffer slot.
- Drain when `wb_stall==0`:
  - port 1 takes the head if `count ≥ 1`;
  - port 2 takes head+1 if `count ≥ 2`.
  - `wen1`/`wen2` are 1 only for drained entries.
- Same-register conflict: if both drained entries have equal `rd`, force `wen1=0`. The younger entry (port 2) wins.
- Port outputs are combinational from registered buffer state only, with no input-to-output path from `src_*`.
- `flush==1`: the next state is empty, `src_ready` is all 0, `wen1=wen2=0` this cycle. Flush beats both stall and drain.
- Reset (`reset==0`): identical to flush. After the edge, `count=0`, `src_ready` is live from the next cycle, and `wen*`, `fw_hit` are 0.

## Timing
- Latency: a result accepted at edge t appears on `wen*` in cycle t+1 if the buffer was empty and there is no stall. The register file commits it at the end of t+1.
- Throughput: 2 accepts and 2 drains per cycle sustained.
- Full (`count==DEPTH`): `src_ready` is all 0 that cycle, even if a drain is happening.
- `count==DEPTH−1`: only the highest-priority valid source is ready.
- Pointers wrap modulo DEPTH; the wrap bit distinguishes full from empty.
- Stall: `wen*` stays 0 while stalled. Entries are held unchanged, and the head is re-presented on the first unstalled cycle.

## Configuration
- `WB_BYPASS_EN` defined:
  - for each k, `fw_hit[k]=1` when `fw_rs[k]!=0` and some valid buffer entry has `rd==fw_rs[k]`;
  - `fw_data[k]` is the youngest such entry;
  - purely combinational from buffer state.
- Undefined: `fw_hit=0`, `fw_data=0`, and no compare logic is built. The ports remain present.

## Structure
- Shared package `wb_pkg`:
  - `AW`;
  - `wb_entry_t` {rd[AW], data[WIDTH]};
  - default `WB_DEPTH=4`, `WB_NSRC=4`.
- Sub-module `wb_fifo`: 2-in/2-out circular buffer exposing entries, valid mask, `count`, and flush/reset clearing. `wb_arbiter` holds the ready grant, the rd==0 drop, the conflict rule and the bypass.

## Test plan
- Basic accept: empty buffer, src0 {rd=5, data=0xA5}. Accepted at t. Cycle t+1: `rd1=5`, `wdata1=0xA5`, `wen1=1`, `wen2=0`.
- Priority: all four sources valid, rd 1..4, buffer empty, no stall. `src_ready=4'b0011`. Next cycle port 1 writes rd1, port 2 writes rd2. Sources 2/3 are accepted the following cycle.
- Fill and full: `wb_stall=1`, two sources valid each cycle.
  - `count` steps 0→2→4, then `src_ready=0`.
  - Release stall: the entries drain in order, 2 per cycle.
- Conflict and drop:
  - src0 {rd=7, 0x11} and src1 {rd=7, 0x22} in one cycle: `wen1=0`, `wen2=1`, `wdata2=0x22`.
  - A src with rd=0 never produces `wen`.
- Flush and reset: stall with 3 entries, then `flush=1`. Next cycle `count=0`, no `wen`. Repeat with `reset=0` and check the same result.
- Bypass (`WB_BYPASS_EN`): stall with entries {rd=9, 0x1} then {rd=9, 0x2}.
  - `fw_rs=9` gives `fw_hit=1`, `fw_data=0x2`.
  - `fw_rs=0` gives no hit.
  - With the macro undefined, `fw_hit` stays 0.
